// File: rtl/mem_arb_pkg.sv
// Shared encodings for the RAM port arbiter: FSM states and owner codes.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC     = 2'd1,
    RD_WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_DBG  = 2'b10
  } owner_e;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational two-way picker: sole requester wins; ties go to debug when
// forced, otherwise to whichever requester did not own the previous access.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic   req_cpu,
  input  logic   req_dbg,
  input  logic   force_dbg,
  input  owner_e last_owner,
  output logic   valid,
  output owner_e pick
);

  always_comb begin
    valid = req_cpu | req_dbg;
    pick  = OWN_CPU;
    if (req_dbg && (!req_cpu || force_dbg || (last_owner == OWN_CPU))) begin
      pick = OWN_DBG;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port data RAM between the CPU and the debug engine,
// sequencing address/write and read-latency phases and steering read data.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DW      = 16,
  parameter int AW      = 16,
  parameter int RAM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  input  logic          dbg_priority,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout,
  output logic [1:0]    owner,
  output logic          cpu_stall
);

  localparam int CW = 2;

  state_e        state_q, state_d;
  owner_e        own_q, own_d;
  owner_e        last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          we_q, we_d;
  logic          pick_valid;
  owner_e        pick;
  logic          acc, rd_done;

  mem_arb_rr_pick u_pick (
    .req_cpu    (cpu_req),
    .req_dbg    (dbg_req),
    .force_dbg  (dbg_priority),
    .last_owner (last_q),
    .valid      (pick_valid),
    .pick       (pick)
  );

  // last_q resets to debug so the CPU takes the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      own_q   <= OWN_NONE;
      last_q  <= OWN_DBG;
      cnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    we_d    = we_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = ACC;
          own_d   = pick;
          last_d  = pick;
          if (pick == OWN_DBG) begin
            addr_d = dbg_addr;
            din_d  = dbg_wdata;
            we_d   = dbg_we;
          end else begin
            addr_d = cpu_addr;
            din_d  = cpu_wdata;
            we_d   = cpu_we;
          end
        end
      end
      ACC: begin
        we_d = 1'b0;
        if (we_q) begin
          state_d = IDLE;
        end else begin
          state_d = RD_WAIT;
          cnt_d   = CW'(RAM_LAT - 1);
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign acc        = (state_q == ACC);
  assign rd_done    = (state_q == RD_WAIT) && (cnt_q == '0);
  assign cpu_gnt    = acc && (own_q == OWN_CPU);
  assign dbg_gnt    = acc && (own_q == OWN_DBG);
  assign cpu_rvalid = rd_done && (own_q == OWN_CPU);
  assign dbg_rvalid = rd_done && (own_q == OWN_DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_dout : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_dout : '0;
  assign mem_addr   = addr_q;
  assign mem_din    = din_q;
  assign mem_we     = we_q;
  assign owner      = (state_q == IDLE) ? OWN_NONE : own_q;
  assign cpu_stall  = cpu_req & ~cpu_gnt;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 256x16 data RAM between two requesters: the RISC processor and a debug/dump engine.
- The debug engine is the memory-dump stepper or a future loader.
- Replaces the static dump-mode address mux with a req/gnt arbiter.
- Sequences each RAM access (address/write phase, then read-latency wait) and routes read data back to the owning requester.

Parameters:
- DW, 16, data width.
- AW, 16, address width (RAM decodes the low bits).
- RAM_LAT, 1, RAM read latency in clk cycles (range 1..3).

Ports:
- clk  in  1  system clock; RAM is clocked by the same clock.
- reset  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  CPU access request; held high, fields stable, until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_gnt  out  1  one-cycle pulse: CPU access issued.
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid.
- cpu_rdata  out  DW  read data to CPU.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same as the cpu_* set, for the debug requester.
- dbg_priority  in  1  1 = debug wins every conflict; 0 = round-robin.
- mem_addr  out  AW  RAM address (registered).
- mem_din  out  DW  RAM write data (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_dout  in  DW  RAM read data.
- owner  out  2  00 idle, 01 CPU, 10 debug; drives the status display.
- cpu_stall  out  1  cpu_req high and cpu_gnt low this cycle.

Behaviour:
- Reset (async, any state):
  - state = IDLE; last_owner = DBG, so the CPU wins the first tie.
  - All outputs 0, including mem_we, mem_addr, mem_din and both gnt/rvalid.
  - A read in flight is abandoned: no rvalid is issued for it.
- States: IDLE, ACC, RD_WAIT; registered owner_r in {CPU, DBG}.
- IDLE, no requests: remain in IDLE.
- IDLE, requests pending: pick a winner.
  - Only one requester active: it wins.
  - Both active, dbg_priority = 1: DBG wins.
  - Both active, dbg_priority = 0: the requester other than last_owner wins.
- IDLE -> ACC on the winning edge:
  - Load mem_addr and mem_din from the winner; mem_we = winner's we.
  - Set owner_r and last_owner.
- ACC (exactly 1 cycle):
  - gnt of owner_r high; mem_we high only if the access is a write.
  - RAM samples on the closing edge.
  - Write: -> IDLE, with mem_we cleared.
  - Read: -> RD_WAIT, with wait counter = RAM_LAT - 1.
- RD_WAIT:
  - mem_addr held; mem_we 0.
  - Counter decrements each cycle.
  - At counter 0: rvalid of owner_r high for that cycle, then -> IDLE.
- rdata routing:
  - rdata of owner_r = mem_dout combinationally while that requester's rvalid is high.
  - The non-owning requester's rdata reads 0.
- Latency:
  - Request seen in IDLE at cycle N: gnt in N+1, rvalid in N+1+RAM_LAT.
  - Next arbitration in cycle N+2 (write) or N+2+RAM_LAT (read).
- Fairness: with both requesters saturating and dbg_priority = 0, grants strictly alternate.
- Requests are only sampled in IDLE.
  - A request raised during ACC/RD_WAIT waits for IDLE.
  - A request dropped before its gnt is simply never served. No error is raised; the requester protocol forbids this.
- owner: reflects owner_r in ACC/RD_WAIT; 00 in IDLE.
- Address width: mem_addr carries the full 16-bit address; wrap above 255 is the RAM's decode (0x0100 aliases 0x0000). The arbiter does no range check.
- dbg_priority changing mid-access: no effect until the next IDLE decision.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encodings IDLE/ACC/RD_WAIT;
  - owner codes OWN_NONE = 2'b00, OWN_CPU = 2'b01, OWN_DBG = 2'b10.
- One sub-module, mem_arb_rr_pick: combinational 2-way picker.
  - Inputs: req_cpu, req_dbg, force_dbg, last_owner.
  - Outputs: valid, pick.
- The FSM, wait counter and output registers stay in the top module.

Test Plan:
- Reset during RD_WAIT (CPU read of 0x0010 in flight): owner = 00 and all outputs 0 immediately; no cpu_rvalid ever follows.
- CPU write 0x0010 <= 0xBEEF, then CPU read of 0x0010, RAM_LAT = 1:
  - cpu_gnt in N+1 with mem_we = 1, mem_addr = 0x0010;
  - read returns cpu_rvalid exactly 2 cycles after its request cycle with cpu_rdata = 0xBEEF.
- CPU and debug both requesting continuously, dbg_priority = 0: first grant goes to the CPU, then grants alternate CPU, DBG, CPU, DBG; cpu_stall is high on the CPU's waiting cycles.
- Same stimulus with dbg_priority = 1: every grant goes to DBG; cpu_stall stays high until dbg_req drops, then the CPU is granted in the next IDLE decision.
- Debug read of 0x0105 after a CPU write of 0x0005 <= 0x1234: dbg_rdata = 0x1234 (alias); cpu_rvalid stays 0 and cpu_rdata reads 0 throughout.
- RAM_LAT = 3, debug read: dbg_gnt in N+1, dbg_rvalid in N+4, mem_addr stable N+1..N+4; a CPU request raised at N+2 is granted at N+6.
